// File: rtl/relay_word_scheduler.sv
// Relay word scheduler: queues channel-10 relay writes, drives each for HOLD_CYCLES then GAP_CYCLES of zero.
// Latency: a write into an idle, empty queue drives from the next edge; no backpressure, full-queue writes drop and set OVF.

module relay_word_fifo #(
   parameter int W     = 15,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push_vld,
   input  logic [W-1:0] push_dat,
   input  logic         pop_vld,
   output logic [W-1:0] head_dat,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full     = (cnt_q == FULL_CNT);
   assign empty    = (cnt_q == '0);
   assign head_dat = mem_q[rd_ptr_q];
   // A push into a full queue lands only when the head leaves on the same edge.
   assign do_pop   = pop_vld && !empty;
   assign do_push  = push_vld && (!full || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

module relay_word_scheduler #(
   parameter int HOLD_CYCLES = 8,
   parameter int GAP_CYCLES  = 2,
   parameter int DEPTH       = 4,
   parameter int GATE_DELAY  = 20
) (
   input  logic        CLOCK,
   input  logic        rst,
   input  logic        WCH10,
   input  logic [14:0] CHWL,
   input  logic        GOJAM,
   input  logic        CLROVF,
   output logic [10:0] RLYB,
   output logic [3:0]  RYWD,
   output logic        RLYACT,
   output logic        FULL,
   output logic        OVF
);
   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 || GAP_CYCLES < 1 || GAP_CYCLES > 255 ||
       DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || GATE_DELAY < 0) begin : g_bad_param
      $error("relay_word_scheduler: parameter out of legal range");
   end

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

   localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [10:0] rlyb_q, rlyb_d;
   logic [3:0]  rywd_q, rywd_d;
   logic        rlyact_q, rlyact_d;
   logic        ovf_q, ovf_d;

   logic        push_req, pop, drop;
   logic        fifo_full, fifo_empty;
   logic [14:0] head_dat;

   // Address zero is a no-op write, and a flush edge ignores the strobe entirely.
   assign push_req = WCH10 && (CHWL[14:11] != 4'd0) && !GOJAM;
   assign drop     = push_req && fifo_full && !pop;

   relay_word_fifo #(.W(15), .DEPTH(DEPTH)) u_fifo (
      .clk      (CLOCK),
      .rst      (rst),
      .flush    (GOJAM),
      .push_vld (push_req),
      .push_dat (CHWL),
      .pop_vld  (pop),
      .head_dat (head_dat),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rlyb_d   = rlyb_q;
      rywd_d   = rywd_q;
      rlyact_d = rlyact_q;
      pop      = 1'b0;
      if (GOJAM) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         rlyb_d   = '0;
         rywd_d   = '0;
         rlyact_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!fifo_empty) begin
                  pop      = 1'b1;
                  state_d  = S_DRIVE;
                  cnt_d    = HOLD_LOAD;
                  rlyb_d   = head_dat[10:0];
                  rywd_d   = head_dat[14:11];
                  rlyact_d = 1'b1;
               end
            end
            S_DRIVE: begin
               if (cnt_q == 8'd0) begin
                  state_d  = S_GAP;
                  cnt_d    = GAP_LOAD;
                  rlyb_d   = '0;
                  rywd_d   = '0;
                  rlyact_d = 1'b0;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            S_GAP: begin
               if (cnt_q != 8'd0) begin
                  cnt_d = cnt_q - 8'd1;
               end else if (!fifo_empty) begin
                  pop      = 1'b1;
                  state_d  = S_DRIVE;
                  cnt_d    = HOLD_LOAD;
                  rlyb_d   = head_dat[10:0];
                  rywd_d   = head_dat[14:11];
                  rlyact_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // A drop on the same edge as a clear leaves the flag set.
   always_comb begin
      ovf_d = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (CLROVF) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge CLOCK or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rlyb_q   <= '0;
         rywd_q   <= '0;
         rlyact_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rlyb_q   <= rlyb_d;
         rywd_q   <= rywd_d;
         rlyact_q <= rlyact_d;
         ovf_q    <= ovf_d;
      end
   end

   assign RLYB   = rlyb_q;
   assign RYWD   = rywd_q;
   assign RLYACT = rlyact_q;
   assign FULL   = fifo_full;
   assign OVF    = ovf_q;
endmodule

// File: tb/tb_relay_word_scheduler.sv
// Bench for relay_word_scheduler: directed scenarios then random traffic, checked against a timeline queue model.
module tb_relay_word_scheduler;
   localparam int HOLD  = 8;
   localparam int GAP   = 2;
   localparam int DEPTH = 4;
   localparam int NONE  = -1000000;

   logic        CLOCK = 1'b0;
   logic        rst, WCH10, GOJAM, CLROVF;
   logic [14:0] CHWL;
   logic [10:0] RLYB;
   logic [3:0]  RYWD;
   logic        RLYACT, FULL, OVF;

   int n_pass  = 0;
   int n_total = 0;

   // Model: queue of words plus the edge at which the driver is next free.
   logic [14:0] mq[$];
   logic [14:0] m_cur;
   int          m_edge, m_free, m_start;
   bit          m_ovf;

   relay_word_scheduler #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .DEPTH(DEPTH), .GATE_DELAY(20)) dut (
      .CLOCK  (CLOCK),
      .rst    (rst),
      .WCH10  (WCH10),
      .CHWL   (CHWL),
      .GOJAM  (GOJAM),
      .CLROVF (CLROVF),
      .RLYB   (RLYB),
      .RYWD   (RYWD),
      .RLYACT (RLYACT),
      .FULL   (FULL),
      .OVF    (OVF)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      mq.delete();
      m_start = NONE;
      m_free  = 0;
      m_ovf   = 1'b0;
   endtask

   task automatic model_step();
      bit pop_now;
      bit drop;
      drop = 1'b0;
      m_edge++;
      if (GOJAM) begin
         mq.delete();
         m_start = NONE;
         m_free  = m_edge;
         if (CLROVF) m_ovf = 1'b0;
      end else begin
         pop_now = (m_edge >= m_free) && (mq.size() > 0);
         if (pop_now) begin
            m_cur   = mq.pop_front();
            m_start = m_edge;
            m_free  = m_edge + HOLD + GAP;
         end
         if (WCH10 && CHWL[14:11] != 4'd0) begin
            if (mq.size() < DEPTH) mq.push_back(CHWL);
            else drop = 1'b1;
         end
         if (drop) m_ovf = 1'b1;
         else if (CLROVF) m_ovf = 1'b0;
      end
   endtask

   task automatic cmp_all();
      bit drv;
      drv = (m_edge - m_start) < HOLD;
      chk("rlyb",   32'(RLYB),   drv ? 32'(m_cur[10:0])  : 32'd0);
      chk("rywd",   32'(RYWD),   drv ? 32'(m_cur[14:11]) : 32'd0);
      chk("rlyact", 32'(RLYACT), 32'(drv));
      chk("full",   32'(FULL),   32'(mq.size() == DEPTH));
      chk("ovf",    32'(OVF),    32'(m_ovf));
   endtask

   task automatic tick();
      model_step();
      @(posedge CLOCK);
      #1;
      cmp_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [14:0] d);
      WCH10 = 1'b1;
      CHWL  = d;
      tick();
      WCH10 = 1'b0;
      CHWL  = '0;
   endtask

   initial begin
      rst = 1'b0; WCH10 = 1'b0; GOJAM = 1'b0; CLROVF = 1'b0; CHWL = '0;
      m_edge = 0;
      model_reset();
      #1 rst = 1'b1;
      #2;
      chk("reset_rlyb",   32'(RLYB),   32'd0);
      chk("reset_rywd",   32'(RYWD),   32'd0);
      chk("reset_rlyact", 32'(RLYACT), 32'd0);
      chk("reset_full",   32'(FULL),   32'd0);
      chk("reset_ovf",    32'(OVF),    32'd0);
      #9 rst = 1'b0;
      ticks(2);

      // Single write: drive on n+1..n+8, zero on n+9..n+10.
      wr(15'h5ABC);
      tick();
      chk("single_rlyb_n1", 32'(RLYB), 32'h2BC);
      chk("single_rywd_n1", 32'(RYWD), 32'hB);
      chk("single_act_n1",  32'(RLYACT), 32'd1);
      ticks(7);
      chk("single_act_n8",  32'(RLYACT), 32'd1);
      tick();
      chk("single_act_n9",  32'(RLYACT), 32'd0);
      chk("single_rlyb_n9", 32'(RLYB), 32'd0);
      ticks(2);
      chk("single_act_n11", 32'(RLYACT), 32'd0);
      ticks(3);

      // Five back-to-back writes, addresses 1..5.
      for (int a = 1; a <= 5; a++) wr({4'(a), 11'(16'h100 + a)});
      chk("five_ovf", 32'(OVF), 32'd0);
      ticks(55);

      // Fill during a drive: two of six writes must drop.
      wr(15'h0801);
      for (int a = 1; a <= 6; a++) wr({4'(a + 2), 11'(16'h2A0 + a)});
      chk("ovf_full", 32'(FULL), 32'd1);
      chk("ovf_set",  32'(OVF),  32'd1);
      CLROVF = 1'b1;
      tick();
      CLROVF = 1'b0;
      chk("ovf_clear", 32'(OVF), 32'd0);
      ticks(60);

      // Address-zero write is a no-op.
      wr(15'h07FF);
      ticks(3);
      chk("zero_addr_act",  32'(RLYACT), 32'd0);
      chk("zero_addr_full", 32'(FULL),   32'd0);

      // Flush mid-drive with three queued and a concurrent write.
      wr(15'h1111);
      wr(15'h2222);
      wr(15'h3333);
      wr(15'h4444);
      GOJAM = 1'b1; WCH10 = 1'b1; CHWL = 15'h7FFF;
      tick();
      GOJAM = 1'b0; WCH10 = 1'b0; CHWL = '0;
      chk("gojam_act",  32'(RLYACT), 32'd0);
      chk("gojam_rlyb", 32'(RLYB),   32'd0);
      chk("gojam_full", 32'(FULL),   32'd0);
      chk("gojam_ovf",  32'(OVF),    32'd0);
      ticks(20);
      chk("gojam_after_act", 32'(RLYACT), 32'd0);

      // Async reset pulse mid-drive with a full queue and OVF set.
      wr(15'h0C55);
      for (int a = 1; a <= 5; a++) wr({4'(a + 8), 11'(16'h010 + a)});
      tick();
      chk("pre_rst_act", 32'(RLYACT), 32'd1);
      chk("pre_rst_ovf", 32'(OVF),    32'd1);
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("rst_mid_act",  32'(RLYACT), 32'd0);
      chk("rst_mid_rlyb", 32'(RLYB),   32'd0);
      chk("rst_mid_full", 32'(FULL),   32'd0);
      chk("rst_mid_ovf",  32'(OVF),    32'd0);
      cmp_all();
      #4 rst = 1'b0;
      ticks(15);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         WCH10  = ($urandom_range(0, 2) == 0);
         CHWL   = 15'($urandom);
         GOJAM  = ($urandom_range(0, 96) == 0);
         CLROVF = !GOJAM && ($urandom_range(0, 22) == 0);
         tick();
      end
      WCH10 = 1'b0; GOJAM = 1'b0; CLROVF = 1'b0;
      ticks(50);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
